pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator: one shared period counter drives CHANNELS comparators, each with its own duty value. Per-channel duty values and the common period are double-buffered. New values take effect only at a period boundary, so there are no runt or glitch pulses. It supports edge-aligned and centre-aligned modes and replaces the single fixed-period, 8-bit, switch-driven PWM used for motor/LED drive on the board.

---
 rtl/pwm_multi_pkg.sv | 14 +
 rtl/pwm_multi_if.sv | 18 +
 rtl/pwm_multi_channel.sv | 35 +++
 rtl/pwm_multi.sv | 96 +++++++++
 tb/tb_pwm_multi.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_multi_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;

  localparam int MAX_CHANNELS = 16;

  // Width of a channel index; a single channel still gets a 1-bit address.
  function automatic int addr_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Duty-write bus: single-cycle strobe, channel index and duty value, no backpressure.
interface pwm_multi_if
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);

  localparam int AW = addr_width(CHANNELS);

  logic             WE;
  logic [AW-1:0]    ADDR;
  logic [WIDTH-1:0] WDATA;

  modport master (output WE, ADDR, WDATA);
  modport slave  (input  WE, ADDR, WDATA);

endinterface

// File: rtl/pwm_multi_channel.sv
// One PWM channel: shadow/active duty pair plus the registered comparator.
module pwm_channel #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic             WR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [WIDTH-1:0] CNT,
  output logic             PWM
);

  logic [WIDTH-1:0] duty_shd;
  logic [WIDTH-1:0] duty_act;

  // Shadow takes every write; active copies it on LOAD, taking a coincident write straight through.
  always_ff @(posedge CLK) begin
    if (RST) begin
      duty_shd <= '0;
      duty_act <= '0;
      PWM      <= 1'b0;
    end else begin
      if (WR) begin
        duty_shd <= WDATA;
      end
      if (LOAD) begin
        duty_act <= WR ? WDATA : duty_shd;
      end
      PWM <= EN && (CNT < duty_act);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/centre-aligned period counter feeding CHANNELS comparators.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                MODE,
  input  logic [WIDTH-1:0]    PERIOD,
  pwm_multi_if.slave          wbus,
  output logic [CHANNELS-1:0] PWM_OUT,
  output logic                PERIOD_END
);

  localparam int               AW  = addr_width(CHANNELS);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] period_act;
  pwm_mode_t        mode_act;
  pwm_dir_t         dir;
  pwm_dir_t         dir_nxt;
  logic             boundary;
  logic             load;

  // Last cycle of the period; P=0 makes every cycle a boundary in both modes.
  always_comb begin
    boundary = 1'b0;
    if (period_act == '0) begin
      boundary = 1'b1;
    end else if (mode_act == PWM_EDGE) begin
      boundary = (cnt == period_act);
    end else begin
      boundary = (cnt == ONE) && ((dir == DIR_DOWN) || (period_act == ONE));
    end
  end

  // While disabled the active settings track their inputs every cycle.
  assign load = boundary || !EN;

  // Next counter value and direction: wrap at boundary, turn around at the top in centre mode.
  always_comb begin
    cnt_nxt = cnt + ONE;
    dir_nxt = dir;
    if (!EN || boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (mode_act == PWM_CENTER) begin
      if (dir == DIR_DOWN) begin
        cnt_nxt = cnt - ONE;
      end else if (cnt == period_act) begin
        cnt_nxt = cnt - ONE;
        dir_nxt = DIR_DOWN;
      end
    end
  end

  // Counter state, period/mode double buffer and the registered period-end pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      dir        <= DIR_UP;
      period_act <= '0;
      mode_act   <= PWM_EDGE;
      PERIOD_END <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      PERIOD_END <= EN && boundary;
      if (load) begin
        period_act <= PERIOD;
        mode_act   <= pwm_mode_t'(MODE);
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (EN),
      .LOAD  (load),
      .WR    (wbus.WE && (wbus.ADDR == AW'(k))),
      .WDATA (wbus.WDATA),
      .CNT   (cnt),
      .PWM   (PWM_OUT[k])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (WIDTH=8, CHANNELS=4).
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic                CLK = 1'b0;
  logic                RST;
  logic                EN;
  logic                MODE;
  logic [WIDTH-1:0]    PERIOD;
  logic [CHANNELS-1:0] PWM_OUT;
  logic                PERIOD_END;

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] pat;
  logic [3:0]  acc;

  pwm_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) wbus ();

  pwm_multi #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .MODE       (MODE),
    .PERIOD     (PERIOD),
    .wbus       (wbus),
    .PWM_OUT    (PWM_OUT),
    .PERIOD_END (PERIOD_END)
  );

  // 100 MHz clock
  always #5 CLK = ~CLK;

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic mode, input logic [WIDTH-1:0] period);
    EN     = en;
    MODE   = mode;
    PERIOD = period;
  endtask

  task automatic writeDuty(input int ch, input logic [WIDTH-1:0] d);
    wbus.WE    = 1'b1;
    wbus.ADDR  = 2'(ch);
    wbus.WDATA = d;
    tick();
    wbus.WE    = 1'b0;
  endtask

  task automatic waitPeriodEnd(input string tag, input int budget);
    int i = 0;
    while (PERIOD_END !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    checkOutput({tag, ".seen"}, 32'(PERIOD_END), 32'd1);
  endtask

  // Measures one period of n cycles starting right after a PERIOD_END sample;
  // optionally issues one duty write on step writeAt.
  task automatic measurePeriod(input string tag, input int n,
                               input int e0, input int e1, input int e2, input int e3,
                               input int writeAt, input int wch, input logic [WIDTH-1:0] wd,
                               output logic [15:0] pat1);
    int   hi [4];
    int   ex [4];
    int   early;
    logic lastPe;
    ex    = '{e0, e1, e2, e3};
    hi    = '{0, 0, 0, 0};
    early = 0;
    lastPe = 1'b0;
    pat1  = '0;
    for (int i = 1; i <= n; i++) begin
      if (i == writeAt) begin
        wbus.WE    = 1'b1;
        wbus.ADDR  = 2'(wch);
        wbus.WDATA = wd;
      end
      tick();
      wbus.WE = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (PWM_OUT[k] === 1'b1) hi[k]++;
      end
      pat1[i-1] = PWM_OUT[1];
      if (i == n) lastPe = PERIOD_END;
      else if (PERIOD_END !== 1'b0) early++;
    end
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s.ch%0d_high", tag, k), 32'(hi[k]), 32'(ex[k]));
    end
    checkOutput({tag, ".pe_last"}, 32'(lastPe), 32'd1);
    checkOutput({tag, ".pe_early"}, 32'(early), 32'd0);
  endtask

  initial begin
    // Reset held for two cycles while enabled and writing
    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd9);
    wbus.WE    = 1'b1;
    wbus.ADDR  = 2'd2;
    wbus.WDATA = 8'd55;
    tick();
    tick();
    checkOutput("reset.pwm", 32'(PWM_OUT), 32'd0);
    checkOutput("reset.pe", 32'(PERIOD_END), 32'd0);
    checkOutput("reset.cnt", 32'(dut.cnt), 32'd0);
    checkOutput("reset.shd2", 32'(dut.g_ch[2].u_ch.duty_shd), 32'd0);
    checkOutput("reset.act2", 32'(dut.g_ch[2].u_ch.duty_act), 32'd0);
    checkOutput("reset.act0", 32'(dut.g_ch[0].u_ch.duty_act), 32'd0);
    RST     = 1'b0;
    wbus.WE = 1'b0;
    acc = '0;
    repeat (12) begin
      tick();
      acc |= PWM_OUT;
    end
    checkOutput("reset.idle_pwm", 32'(acc), 32'd0);

    // Edge mode P=9, duties {0,3,9,10} loaded while disabled
    applyStimulus(1'b0, 1'b0, 8'd9);
    writeDuty(0, 8'd0);
    writeDuty(1, 8'd3);
    writeDuty(2, 8'd9);
    writeDuty(3, 8'd10);
    checkOutput("disabled.pwm", 32'(PWM_OUT), 32'd0);
    EN = 1'b1;
    waitPeriodEnd("edge.sync", 30);
    measurePeriod("edge", 10, 0, 3, 9, 10, -1, 0, 8'd0, pat);

    // Double buffering: mid-period write, then a write on the boundary cycle
    measurePeriod("dbuf.cur", 10, 0, 3, 9, 10, 5, 1, 8'd7, pat);
    measurePeriod("dbuf.next", 10, 0, 7, 9, 10, -1, 0, 8'd0, pat);
    measurePeriod("wthru.cur", 10, 0, 7, 9, 10, 10, 1, 8'd2, pat);
    measurePeriod("wthru.next", 10, 0, 2, 9, 10, -1, 0, 8'd0, pat);

    // Period change 9 -> 4 mid-period
    PERIOD = 8'd4;
    measurePeriod("plen.old", 10, 0, 2, 9, 10, -1, 0, 8'd0, pat);
    measurePeriod("plen.new", 5, 0, 2, 5, 5, -1, 0, 8'd0, pat);

    // Switch to centre mode P=4; channel 2 gets D=5 (P+1, constant high)
    MODE = 1'b1;
    measurePeriod("mode.edge", 5, 0, 2, 5, 5, 1, 2, 8'd5, pat);
    measurePeriod("centre", 8, 0, 3, 8, 8, -1, 0, 8'd0, pat);
    checkOutput("centre.ch1_pattern", 32'(pat[7:0]), 32'h83);

    // P=0: every cycle is a boundary
    PERIOD = 8'd0;
    measurePeriod("centre.last", 8, 0, 3, 8, 8, -1, 0, 8'd0, pat);
    for (int r = 0; r < 3; r++) begin
      measurePeriod($sformatf("p0.%0d", r), 1, 0, 1, 1, 1, -1, 0, 8'd0, pat);
    end

    // Back to edge mode P=9, drop EN at cnt=5
    applyStimulus(1'b1, 1'b0, 8'd9);
    measurePeriod("p0.reload", 1, 0, 1, 1, 1, -1, 0, 8'd0, pat);
    repeat (5) tick();
    checkOutput("en.cnt5", 32'(dut.cnt), 32'd5);
    checkOutput("en.before_pwm", 32'(PWM_OUT), 32'hC);
    EN = 1'b0;
    tick();
    checkOutput("en.off_pwm", 32'(PWM_OUT), 32'd0);
    checkOutput("en.off_pe", 32'(PERIOD_END), 32'd0);
    checkOutput("en.off_cnt", 32'(dut.cnt), 32'd0);
    tick();
    EN = 1'b1;
    tick();
    checkOutput("en.restart_cnt", 32'(dut.cnt), 32'd1);
    checkOutput("en.restart_pwm", 32'(PWM_OUT), 32'hE);

    // Reset mid-period aborts and clears the duties
    repeat (3) tick();
    checkOutput("rst.before_cnt", 32'(dut.cnt), 32'd4);
    checkOutput("rst.before_pwm", 32'(PWM_OUT), 32'hC);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("rst.pwm", 32'(PWM_OUT), 32'd0);
    checkOutput("rst.pe", 32'(PERIOD_END), 32'd0);
    checkOutput("rst.cnt", 32'(dut.cnt), 32'd0);
    checkOutput("rst.act3", 32'(dut.g_ch[3].u_ch.duty_act), 32'd0);
    checkOutput("rst.shd1", 32'(dut.g_ch[1].u_ch.duty_shd), 32'd0);
    acc = '0;
    repeat (12) begin
      tick();
      acc |= PWM_OUT;
    end
    checkOutput("rst.idle_pwm", 32'(acc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
